// File: rtl/cb_pkg.sv
// rtl/cb_pkg.sv - shared types, flag indices and helpers for the CB shift path
package cb_pkg;

    typedef enum logic [2:0] {
        RLC  = 3'd0,
        RRC  = 3'd1,
        RL   = 3'd2,
        RR   = 3'd3,
        SLA  = 3'd4,
        SRA  = 3'd5,
        SWAP = 3'd6,
        SRL  = 3'd7
    } cb_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NIB0 = 2'd1,
        NIB1 = 2'd2,
        DONE = 2'd3
    } nshift_state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    function automatic logic is_left(cb_op_t op);
        return (op == RLC) || (op == RL) || (op == SLA) || (op == SWAP);
    endfunction

endpackage

// File: rtl/nibble_shift.sv
// rtl/nibble_shift.sv - one-nibble shift/rotate slice, time-shared across both nibble cycles
module nibble_shift (
    input  logic [3:0] nibble,
    input  logic       dir,
    input  logic       shift_in,
    input  logic       swap,
    output logic [3:0] nibble_out,
    output logic       shift_out
);

    // dir=1 shifts toward bit 3 (left), dir=0 toward bit 0 (right)
    always_comb begin
        nibble_out = nibble;
        shift_out  = 1'b0;
        if (!swap) begin
            if (dir) begin
                nibble_out = {nibble[2:0], shift_in};
                shift_out  = nibble[3];
            end else begin
                nibble_out = {shift_in, nibble[3:1]};
                shift_out  = nibble[0];
            end
        end
    end

endmodule

// File: rtl/alu_nibble_shifter.sv
// rtl/alu_nibble_shifter.sv - two-cycle nibble-serial executor for CB shift/rotate ops
module alu_nibble_shifter
    import cb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       ready,
    input  logic [2:0] op,
    input  logic [7:0] operand,
    input  logic       cin,
    output logic       valid,
    output logic [7:0] result,
    output logic [3:0] flags
);

    nshift_state_t state_q, state_d;
    cb_op_t        op_q;
    logic [7:0]    operand_q;
    logic          cin_q;
    logic          carry_q;
    logic [3:0]    part_q;

    logic          accept;
    logic          left;
    logic          swap_op;
    logic [3:0]    nib_in;
    logic          nib_shift_in;
    logic [3:0]    nib_out;
    logic          nib_shift_out;
    logic [7:0]    final_result;
    logic [3:0]    final_flags;

    assign ready   = (state_q == IDLE) || (state_q == DONE);
    assign valid   = (state_q == DONE);
    assign accept  = start && ready;
    assign left    = is_left(op_q);
    assign swap_op = (op_q == SWAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = NIB0;
            NIB0:    state_d = NIB1;
            NIB1:    state_d = DONE;
            DONE:    state_d = start ? NIB0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Left ops take the low nibble first, right ops the high nibble first
    always_comb begin
        nib_in       = operand_q[3:0];
        nib_shift_in = carry_q;
        if ((state_q == NIB0) == left) begin
            nib_in = operand_q[3:0];
        end else begin
            nib_in = operand_q[7:4];
        end
        if (state_q == NIB0) begin
            case (op_q)
                RLC:     nib_shift_in = operand_q[7];
                RRC:     nib_shift_in = operand_q[0];
                RL:      nib_shift_in = cin_q;
                RR:      nib_shift_in = cin_q;
                SRA:     nib_shift_in = operand_q[7];
                default: nib_shift_in = 1'b0;
            endcase
        end
    end

    nibble_shift u_nibble_shift (
        .nibble     (nib_in),
        .dir        (left),
        .shift_in   (nib_shift_in),
        .swap       (swap_op),
        .nibble_out (nib_out),
        .shift_out  (nib_shift_out)
    );

    // SWAP and right ops leave the NIB0 nibble in the high half
    always_comb begin
        final_result = (left && !swap_op) ? {nib_out, part_q} : {part_q, nib_out};
        final_flags          = 4'h0;
        final_flags[FLAG_Z]  = (final_result == 8'h00);
        final_flags[FLAG_N]  = 1'b0;
        final_flags[FLAG_H]  = 1'b0;
        final_flags[FLAG_C]  = swap_op ? 1'b0 : (left ? operand_q[7] : operand_q[0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= RLC;
            operand_q <= 8'h00;
            cin_q     <= 1'b0;
            carry_q   <= 1'b0;
            part_q    <= 4'h0;
            result    <= 8'h00;
            flags     <= 4'h0;
        end else begin
            if (accept) begin
                op_q      <= cb_op_t'(op);
                operand_q <= operand;
                cin_q     <= cin;
            end
            if (state_q == NIB0) begin
                part_q  <= nib_out;
                carry_q <= nib_shift_out;
            end
            if (state_q == NIB1) begin
                result <= final_result;
                flags  <= final_flags;
            end
        end
    end

endmodule

// File: doc/alu_nibble_shifter.md
# alu_nibble_shifter

Nibble-serial executor for the eight CB-prefix shift/rotate operations (RLC, RRC, RL, RR, SLA, SRA, SWAP, SRL). It drives the 4-bit datapath over two nibble cycles and carries the shifted-out bit between nibbles. Left-direction ops process the low nibble first; right-direction ops process the high nibble first. It sits beside the ALU as the issue/compute side of the shift path and returns the 8-bit result plus the F-register flag nibble to the register file.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  request; accepted only when ready=1
- ready  out  1  high in IDLE and DONE
- op  in  3  CB op: 0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SWAP, 7 SRL
- operand  in  8  source byte
- cin  in  1  current C flag (used by RL/RR only)
- valid  out  1  one-cycle pulse, result/flags valid
- result  out  8  shifted byte, held until next accept
- flags  out  4  {Z,N,H,C}, aligned to F[7:4], held with result

## Operation
- Accept: start & ready latches op, operand, cin into internal registers. Later input changes have no effect.
- States: IDLE → NIB0 → NIB1 → DONE. In DONE, start → NIB0, otherwise → IDLE. start in NIB0/NIB1 is ignored.
- Direction: left = RLC, RL, SLA, SWAP, with low nibble in NIB0 and high nibble in NIB1. Right = RRC, RR, SRA, SRL, with high nibble in NIB0 and low nibble in NIB1.
- Shift-in bit for the NIB0 nibble:
  - RLC: operand[7]; RL: cin; SLA: 0
  - RRC: operand[0]; RR: cin; SRA: operand[7]; SRL: 0
- The bit shifted out of the NIB0 nibble (bit3 for left, bit0 for right) is registered and used as the shift-in for NIB1.
- SWAP: each nibble passes unshifted to the opposite half; no inter-nibble bit.
- C flag: operand[7] for left ops, operand[0] for right ops, 0 for SWAP.
- Z = (result == 0). N = 0 and H = 0 always.
- result and flags update at entry to DONE only. They are held through IDLE and through the next NIB0/NIB1.

## Timing
- Reset values: state IDLE, ready 1, valid 0, result 0x00, flags 0x0, internal carry 0.
- Latency: start accepted at edge T, NIB0 in cycle T+1, NIB1 in T+2, valid=1 in T+3.
- Throughput: one op per 3 cycles when start is held across DONE.
- valid is high exactly one cycle per accepted op and never without a prior accept.
- Async reset at any point, including mid-NIB1: outputs return to reset values immediately. No valid pulse is produced for the aborted op.
- Reset deasserted with start=1: accept occurs at the first rising edge after deassertion.

## Structure
- Shared package cb_pkg holds:
  - enum cb_op_t with the 3-bit encodings above
  - enum nshift_state_t {IDLE, NIB0, NIB1, DONE}
  - function is_left(cb_op_t)
  - flag bit index constants FLAG_Z=3, FLAG_N=2, FLAG_H=1, FLAG_C=0
- Sub-module nibble_shift (combinational): inputs nibble[3:0], dir, shift_in, swap; outputs nibble_out[3:0], shift_out. Instantiated once and time-shared across NIB0/NIB1.

## Test plan
- SRL 0x01 → result 0x00, flags 0x9 (Z,C); valid exactly at T+3.
- RL 0x95, cin=1 → 0x2B, flags 0x1. RLC 0x85 → 0x0B, flags 0x1. SLA 0x80 → 0x00, flags 0x9.
- SRA 0x81 → 0xC0, flags 0x1. RR 0x01, cin=0 → 0x00, flags 0x9. RRC 0x01 → 0x80, flags 0x1.
- SWAP 0xF0 → 0x0F, flags 0x0. SWAP 0x00 → 0x00, flags 0x8.
- Back-to-back: start held high with ops SRL 0x02 then SLA 0x41 → valid at T+3 with 0x01 and at T+6 with 0x82. start pulsed in NIB0 is ignored (no extra valid). operand changed after accept does not alter the result.
- Reset asserted in NIB1 of SLA 0xFF → valid never pulses; result/flags 0x00/0x0; ready=1 while reset is high.
